// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a small scan-code FIFO.
// Build option PS2_RX_PARITY_CHECK_EN adds odd-parity validation of each frame.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [3:0]            bit_cnt;
  logic [9:0]            shreg;
  logic [WD_W-1:0]       wd_cnt;
  logic [DEPTH_LOG2-1:0] w_ptr;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2-1:0] w_ptr_nxt;
  logic [DEPTH_LOG2-1:0] r_ptr_nxt;
  logic [7:0]            fifo [DEPTH];

  logic fall;
  logic sample;
  logic frame_done;
  logic frame_ok;
  logic parity_ok;
  logic full;
  logic do_read;
  logic do_write;

  assign fall       = clk_sync[2] & ~clk_sync[1];
  assign sample     = data_sync[1];
  assign frame_done = fall && (bit_cnt == 4'd10);

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^shreg[9:1];
`else
  logic unused_parity;
  assign unused_parity = shreg[9];
  assign parity_ok     = 1'b1;
`endif

  // The stop bit is the live sample; it never enters the shift register.
  assign frame_ok  = ~shreg[0] & sample & parity_ok;

  assign w_ptr_nxt = w_ptr + 1'b1;
  assign r_ptr_nxt = r_ptr + 1'b1;
  assign ready     = (w_ptr != r_ptr);
  assign full      = (w_ptr_nxt == r_ptr);
  assign do_read   = ~nextdata_n & ready;
  // A simultaneous read frees a slot, so a full FIFO still accepts the write.
  assign do_write  = frame_done & frame_ok & (~full | do_read);
  assign data      = fifo[r_ptr];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      bit_cnt   <= 4'd0;
      shreg     <= 10'd0;
      wd_cnt    <= '0;
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      frame_err <= frame_done & ~frame_ok;

      if (fall) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          shreg   <= 10'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {sample, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently to resynchronise.
        if (wd_cnt == WD_LAST) begin
          bit_cnt <= 4'd0;
          shreg   <= 10'd0;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end

      if (do_write) begin
        w_ptr <= w_ptr_nxt;
      end
      if (do_read) begin
        r_ptr <= r_ptr_nxt;
      end

      if (do_read) begin
        overflow <= 1'b0;
      end else if (frame_done && frame_ok && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clrn && do_write) begin
      fifo[w_ptr] <= shreg[8:1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// Self-checking bench for ps2_rx_fifo: table-driven frames, scoreboard of expected bytes.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(5000)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       bad_start;
    logic       bad_par;
    logic       stop;
    logic       exp_wr;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         err_pulses = 0;
  int         lat = 0;
  int         e0 = 0;

  // Counts cycles with frame_err high, so a pulse longer than one cycle shows up.
  always @(negedge clk) if (clrn && frame_err) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at 2 ms, expected to finish");
    $fatal(1);
  end

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_start,
                                           input logic bad_par, input logic stop);
    return {stop, (~^d) ^ bad_par, d, bad_start};
  endfunction

  task automatic send_bit(input logic b);
    ps2_data = b;
    ncyc(4);
    ps2_clk = 1'b0;
    ncyc(8);
    ps2_clk = 1'b1;
    ncyc(4);
  endtask

  task automatic send_frame(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
  endtask

  task automatic read_byte(input string name);
    logic [7:0] e;
    check({name, " ready"}, int'(ready), 1);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: read attempted with 0 expected bytes, expected at least 1", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " data"}, int'(data), int'(e));
    end
    nextdata_n = 1'b0;
    ncyc(1);
    nextdata_n = 1'b1;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) read_byte(name);
    check({name, " empty"}, int'(ready), 0);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h1C, 1'b0, 1'b1, 1'b1, !PAR_EN};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0};

    ncyc(4);
    clrn = 1'b1;
    ncyc(2);
    check("reset ready", int'(ready), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset frame_err", int'(frame_err), 0);

    // Single frame with latency to ready measured from the stop-bit pin fall.
    send_frame(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    ncyc(4);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      ncyc(1);
      if (ready && lat == 0) lat = k;
    end
    ps2_clk = 1'b1;
    ncyc(4);
    n_chk++;
    if (lat < 3 || lat > 4) begin
      n_fail++;
      $display("FAIL first_latency: ready after %0d cycles, expected 3..4", lat);
      lat = 3;
    end
    exp_q.push_back(8'h1C);
    check("first data", int'(data), 8'h1C);
    read_byte("first read");
    check("first ready_after_read", int'(ready), 0);

    // Table of frames, valid and malformed.
    for (int i = 0; i < 8; i++) begin
      e0 = err_pulses;
      send_frame(mk_frame(vecs[i].d, vecs[i].bad_start, vecs[i].bad_par, vecs[i].stop), 11);
      ncyc(2);
      check($sformatf("vec%0d frame_err", i), err_pulses - e0, vecs[i].exp_wr ? 0 : 1);
      check($sformatf("vec%0d ready", i), int'(ready), int'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) exp_q.push_back(vecs[i].d);
      drain($sformatf("vec%0d", i));
    end

    // Fill past capacity: eighth byte is dropped.
    for (int i = 1; i <= 8; i++) begin
      send_frame(mk_frame(8'(i), 1'b0, 1'b0, 1'b1), 11);
      if (i <= 7) exp_q.push_back(8'(i));
      if (i == 7) check("fill overflow_at7", int'(overflow), 0);
    end
    check("fill overflow", int'(overflow), 1);
    read_byte("fill");
    check("fill overflow_cleared", int'(overflow), 0);
    drain("fill");

    // Truncated frame abandoned by the watchdog.
    e0 = err_pulses;
    send_frame(mk_frame(8'h55, 1'b0, 1'b0, 1'b1), 5);
    ncyc(6000);
    send_frame(mk_frame(8'hF0, 1'b0, 1'b0, 1'b1), 11);
    ncyc(2);
    check("watchdog frame_err", err_pulses - e0, 0);
    exp_q.push_back(8'hF0);
    drain("watchdog");

    // Reset mid-frame with bytes queued.
    send_frame(mk_frame(8'h11, 1'b0, 1'b0, 1'b1), 11);
    send_frame(mk_frame(8'h22, 1'b0, 1'b0, 1'b1), 11);
    check("prereset ready", int'(ready), 1);
    send_frame(mk_frame(8'h33, 1'b0, 1'b0, 1'b1), 4);
    clrn = 1'b0;
    ncyc(1);
    clrn = 1'b1;
    check("midreset ready", int'(ready), 0);
    check("midreset overflow", int'(overflow), 0);
    exp_q.delete();
    e0 = err_pulses;
    send_frame(mk_frame(8'h2B, 1'b0, 1'b0, 1'b1), 11);
    ncyc(2);
    check("postreset frame_err", err_pulses - e0, 0);
    exp_q.push_back(8'h2B);
    drain("postreset");

    // Full FIFO with a read in the same cycle as the eighth write.
    for (int i = 0; i < 7; i++) begin
      send_frame(mk_frame(8'h41 + 8'(i), 1'b0, 1'b0, 1'b1), 11);
      exp_q.push_back(8'h41 + 8'(i));
    end
    send_frame(mk_frame(8'h48, 1'b0, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    ncyc(4);
    ps2_clk = 1'b0;
    ncyc(lat - 1);
    read_byte("fullrd strobe");
    exp_q.push_back(8'h48);
    ncyc(8 - lat);
    ps2_clk = 1'b1;
    ncyc(4);
    check("fullrd overflow", int'(overflow), 0);
    check("fullrd ready", int'(ready), 1);
    drain("fullrd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
